// File: rtl/uart_transceiver.sv
// rtl/uart_transceiver.sv - oversampled UART transmitter/receiver with loopback and sticky error flags
module uart_transceiver #(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 transmit_begin,
  output logic                 transmit_active,
  output logic                 transmit_over,
  output logic                 tx,
  input  logic                 rx,
  input  logic                 loopback,
  output logic [DATA_BITS-1:0] out_data,
  output logic                 recieve_over,
  output logic                 rx_valid,
  input  logic                 rx_ack,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int DIV_RAW = CLK_HZ / (BAUD * OVERSAMPLE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int TICK_W  = $clog2(OVERSAMPLE);
  localparam int BIT_W   = $clog2(DATA_BITS);

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  logic [DIV_W-1:0]     baud_cnt_q, baud_cnt_d;
  logic                 s_tick;

  state_t               tx_state_q, tx_state_d;
  logic [TICK_W-1:0]    tx_tick_q, tx_tick_d;
  logic [BIT_W-1:0]     tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_word_q, tx_word_d;
  logic                 transmit_over_q, transmit_over_d;
  logic                 tx_bit_end;
  logic                 tx_serial;
  logic                 tx_par_bit;

  logic                 rx_meta_q, rx_meta_d;
  logic                 rx_sync_q, rx_sync_d;
  logic                 rx_in;
  state_t               rx_state_q, rx_state_d;
  logic [TICK_W-1:0]    rx_tick_q, rx_tick_d;
  logic [BIT_W-1:0]     rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic                 rx_par_q, rx_par_d;
  logic                 rx_sample;
  logic                 stop_strobe;
  logic                 par_bad;

  logic [DATA_BITS-1:0] out_data_q, out_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 parity_err_q, parity_err_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;

  // Free-running oversample tick divider
  always_comb begin
    s_tick     = (baud_cnt_q == DIV_LAST);
    baud_cnt_d = s_tick ? '0 : baud_cnt_q + DIV_W'(1);
  end

  // Transmit FSM: walks start, data (LSB first), optional parity and stop bits
  always_comb begin
    tx_state_d      = tx_state_q;
    tx_tick_d       = tx_tick_q;
    tx_bit_d        = tx_bit_q;
    tx_word_d       = tx_word_q;
    transmit_over_d = 1'b0;
    tx_bit_end      = s_tick && (tx_tick_q == TICK_LAST);
    if (tx_bit_end) begin
      tx_tick_d = '0;
    end else if (s_tick) begin
      tx_tick_d = tx_tick_q + TICK_W'(1);
    end
    case (tx_state_q)
      S_IDLE: begin
        tx_tick_d = '0;
        tx_bit_d  = '0;
        if (transmit_begin) begin
          tx_word_d  = tx_data;
          tx_state_d = S_START;
        end
      end
      S_START: if (tx_bit_end) tx_state_d = S_DATA;
      S_DATA: begin
        if (tx_bit_end) begin
          if (tx_bit_q == BIT_LAST) begin
            tx_state_d = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            tx_bit_d = tx_bit_q + BIT_W'(1);
          end
        end
      end
      S_PARITY: if (tx_bit_end) tx_state_d = S_STOP;
      S_STOP: begin
        if (tx_bit_end) begin
          tx_state_d      = S_IDLE;
          transmit_over_d = 1'b1;
        end
      end
      default: tx_state_d = S_IDLE;
    endcase
  end

  // Serial stream value for the current transmit state
  always_comb begin
    tx_par_bit = (PARITY == 1) ? ~(^tx_word_q) : (^tx_word_q);
    tx_serial  = 1'b1;
    case (tx_state_q)
      S_START:  tx_serial = 1'b0;
      S_DATA:   tx_serial = tx_word_q[tx_bit_q];
      S_PARITY: tx_serial = tx_par_bit;
      default:  tx_serial = 1'b1;
    endcase
  end

  // Receiver input select and two-flop synchroniser for the external line
  always_comb begin
    rx_meta_d = rx;
    rx_sync_d = rx_meta_q;
    rx_in     = loopback ? tx_serial : rx_sync_q;
  end

  // Receive FSM: half-bit start check, then mid-bit sampling of each bit
  always_comb begin
    rx_state_d  = rx_state_q;
    rx_tick_d   = rx_tick_q;
    rx_bit_d    = rx_bit_q;
    rx_shift_d  = rx_shift_q;
    rx_par_d    = rx_par_q;
    stop_strobe = 1'b0;
    rx_sample   = s_tick && (rx_tick_q == ((rx_state_q == S_START) ? TICK_HALF : TICK_LAST));
    if (rx_sample) begin
      rx_tick_d = '0;
    end else if (s_tick) begin
      rx_tick_d = rx_tick_q + TICK_W'(1);
    end
    case (rx_state_q)
      S_IDLE: begin
        rx_tick_d = '0;
        rx_bit_d  = '0;
        if (!rx_in) rx_state_d = S_START;
      end
      S_START: begin
        if (rx_sample) rx_state_d = rx_in ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (rx_sample) begin
          rx_shift_d = {rx_in, rx_shift_q[DATA_BITS-1:1]};
          if (rx_bit_q == BIT_LAST) begin
            rx_state_d = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            rx_bit_d = rx_bit_q + BIT_W'(1);
          end
        end
      end
      S_PARITY: begin
        if (rx_sample) begin
          rx_par_d   = rx_in;
          rx_state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (rx_sample) begin
          stop_strobe = 1'b1;
          rx_state_d  = S_IDLE;
        end
      end
      default: rx_state_d = S_IDLE;
    endcase
  end

  // Delivery, overrun and sticky flags; a flag set this cycle beats a clear by rx_ack
  always_comb begin
    out_data_d   = out_data_q;
    rx_valid_d   = rx_valid_q;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    overrun_d    = overrun_q;
    par_bad      = (PARITY != 0) &&
                   ((PARITY == 1) ? ~(^rx_shift_q ^ rx_par_q) : (^rx_shift_q ^ rx_par_q));
    if (rx_ack) begin
      rx_valid_d   = 1'b0;
      parity_err_d = 1'b0;
      frame_err_d  = 1'b0;
      overrun_d    = 1'b0;
    end
    if (stop_strobe) begin
      if (!rx_valid_q || rx_ack) begin
        out_data_d = rx_shift_q;
        rx_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
      if (par_bad) parity_err_d = 1'b1;
      if (!rx_in)  frame_err_d  = 1'b1;
    end
  end

  // State registers; synchroniser flops reset to the idle line level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      baud_cnt_q      <= '0;
      tx_state_q      <= S_IDLE;
      tx_tick_q       <= '0;
      tx_bit_q        <= '0;
      tx_word_q       <= '0;
      transmit_over_q <= 1'b0;
      rx_meta_q       <= 1'b1;
      rx_sync_q       <= 1'b1;
      rx_state_q      <= S_IDLE;
      rx_tick_q       <= '0;
      rx_bit_q        <= '0;
      rx_shift_q      <= '0;
      rx_par_q        <= 1'b0;
      out_data_q      <= '0;
      rx_valid_q      <= 1'b0;
      parity_err_q    <= 1'b0;
      frame_err_q     <= 1'b0;
      overrun_q       <= 1'b0;
    end else begin
      baud_cnt_q      <= baud_cnt_d;
      tx_state_q      <= tx_state_d;
      tx_tick_q       <= tx_tick_d;
      tx_bit_q        <= tx_bit_d;
      tx_word_q       <= tx_word_d;
      transmit_over_q <= transmit_over_d;
      rx_meta_q       <= rx_meta_d;
      rx_sync_q       <= rx_sync_d;
      rx_state_q      <= rx_state_d;
      rx_tick_q       <= rx_tick_d;
      rx_bit_q        <= rx_bit_d;
      rx_shift_q      <= rx_shift_d;
      rx_par_q        <= rx_par_d;
      out_data_q      <= out_data_d;
      rx_valid_q      <= rx_valid_d;
      parity_err_q    <= parity_err_d;
      frame_err_q     <= frame_err_d;
      overrun_q       <= overrun_d;
    end
  end

  assign transmit_active = (tx_state_q != S_IDLE);
  assign transmit_over   = transmit_over_q;
  assign tx              = loopback ? 1'b1 : tx_serial;
  assign recieve_over    = stop_strobe;
  assign out_data        = out_data_q;
  assign rx_valid        = rx_valid_q;
  assign parity_err      = parity_err_q;
  assign frame_err       = frame_err_q;
  assign overrun         = overrun_q;

endmodule

// File: doc/uart_transceiver.md
UART_TRANSCEIVER -- requirements
Module: uart_transceiver

Interface
REQ-001 Parameter CLK_HZ, default 50000000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 9600, line bit rate.
REQ-003 Parameter OVERSAMPLE, default 16, ticks per bit; even, >=8.
REQ-004 Parameter DATA_BITS, default 8, payload width; legal range 5..9.
REQ-005 Parameter PARITY, default 0; 0 = none, 1 = odd, 2 = even.
REQ-006 Port clk, input, 1, single clock; all state is on its rising edge.
REQ-007 Port rst, input, 1, asynchronous active-high reset.
REQ-008 Port tx_data, input, DATA_BITS, word to send.
REQ-009 Port transmit_begin, input, 1, request to send tx_data.
REQ-010 Port transmit_active, output, 1, transmitter busy.
REQ-011 Port transmit_over, output, 1, one-cycle pulse at end of frame.
REQ-012 Port tx, output, 1, serial line out; idles high.
REQ-013 Port rx, input, 1, serial line in; asynchronous to clk.
REQ-014 Port loopback, input, 1, routes the internal tx serial stream to the receiver.
REQ-015 Port out_data, output, DATA_BITS, last accepted received word.
REQ-016 Port recieve_over, output, 1, one-cycle pulse when a frame's stop bit is sampled.
REQ-017 Port rx_valid, output, 1, out_data holds an unacknowledged word.
REQ-018 Port rx_ack, input, 1, consumer acknowledge.
REQ-019 Port parity_err, frame_err, overrun, outputs, 1 each, sticky error flags.

Function
REQ-020 Baud generator: DIV = max(1, floor(CLK_HZ/(BAUD*OVERSAMPLE))); s_tick pulses one cycle every DIV clocks, free-running from reset.
REQ-021 Frame format: start bit (0), then DATA_BITS LSB first, then a parity bit if PARITY != 0, then one stop bit (1); each bit lasts OVERSAMPLE ticks.
REQ-022 TX FSM states: IDLE, START, DATA, PARITY, STOP; PARITY is skipped when PARITY = 0.
REQ-023 In IDLE, transmit_begin = 1 latches tx_data and moves to START; transmit_active rises the next cycle.
REQ-024 transmit_begin is ignored while transmit_active = 1; the latched word is never altered mid-frame.
REQ-025 At the end of STOP, the FSM returns to IDLE, transmit_active falls and transmit_over pulses in the same cycle; transmit_begin held high in that cycle is accepted the following cycle.
REQ-026 When loopback = 1, the tx pin is held at 1 and the receiver input is the internal serial stream; when loopback = 0, the receiver input is rx through a two-flop synchroniser.
REQ-027 RX FSM states: IDLE, START, DATA, PARITY, STOP.
REQ-028 RX IDLE -> START on a low receiver input.
REQ-029 In START, the receiver waits OVERSAMPLE/2 ticks and samples; if the sample is high, it returns to IDLE (glitch rejection) with no flags changed.
REQ-030 Each subsequent bit is sampled after OVERSAMPLE ticks (mid-bit).
REQ-031 Parity mismatch at stop-sample time sets parity_err; a stop sample of 0 sets frame_err; in both cases the word is still delivered.
REQ-032 At the stop sample, recieve_over pulses; if rx_valid = 0, or rx_ack = 1 in that same cycle, out_data is loaded and rx_valid is set.
REQ-033 If rx_valid = 1 and rx_ack = 0 at the stop sample, out_data is retained, the new word is discarded and overrun is set.
REQ-034 rx_ack = 1 clears rx_valid, parity_err, frame_err and overrun, except that a flag set in the same cycle wins over the clear.
REQ-035 After the stop sample, the RX FSM returns to IDLE immediately, so back-to-back frames are accepted.

Reset
REQ-036 rst = 1 asynchronously forces both FSMs to IDLE, clears the baud counter and the latched tx word, and clears all flags.
REQ-037 During reset: tx = 1, transmit_active = 0, transmit_over = 0, recieve_over = 0, rx_valid = 0, out_data = 0, all error flags 0.
REQ-038 Reset asserted mid-frame aborts the frame with no transmit_over and no recieve_over pulse; the receiver's synchroniser flops reset to 1.

Verification
(All scenarios use CLK_HZ=1600000, BAUD=10000, OVERSAMPLE=16, so DIV=10 and an 8N1 frame is 1600 clk cycles.)
REQ-039 Loopback=1, 8N1, send 0xA5 -> tx pin stays 1; recieve_over, rx_valid=1, out_data=0xA5 within 1600 cycles of begin; transmit_over pulses once; no error flags.
REQ-040 PARITY=2, drive rx with 0x3C and a wrong parity bit 1 -> out_data=0x3C, parity_err=1; rx_ack clears the flag.
REQ-041 Two frames 0x11 then 0x22 on rx, no rx_ack -> out_data=0x11, overrun=1; repeat with rx_ack coincident with the second stop sample -> out_data=0x22, overrun=0.
REQ-042 Rx low pulse of 40 clk (< half bit) -> no recieve_over, flags unchanged; stop bit driven 0 on a valid frame -> frame_err=1.
REQ-043 Assert rst at bit 4 of a TX frame -> tx=1 and transmit_active=0 immediately, no transmit_over; a new send after release produces a correct frame.
REQ-044 DATA_BITS=9, PARITY=1, loopback, send 0x1FF -> out_data=0x1FF, parity bit observed on the serial stream as 0, no errors.
